// File: rtl/sync_fifo.sv
// Single-clock parametrised FIFO with fill level, almost flags, sticky error flags,
// synchronous flush and optional first-word-fall-through read port.
module sync_fifo #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 16,
    parameter int AFULL_LEVEL  = DEPTH - 2,
    parameter int AEMPTY_LEVEL = 1,
    parameter int FWFT         = 0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clr_i,
    input  logic                         wr_stb_i,
    input  logic [WIDTH-1:0]             wr_dat_i,
    output logic                         wr_full_o,
    input  logic                         rd_stb_i,
    output logic [WIDTH-1:0]             rd_dat_o,
    output logic                         rd_empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    output logic                         almost_full_o,
    output logic                         almost_empty_o,
    output logic                         ovf_o,
    output logic                         udf_o
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    if (WIDTH < 1) begin : g_bad_width
        $error("sync_fifo: WIDTH must be >= 1");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be >= 2");
    end
    if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_bad_afull
        $error("sync_fifo: AFULL_LEVEL out of range 1..DEPTH");
    end
    if (AEMPTY_LEVEL < 0 || AEMPTY_LEVEL > DEPTH - 1) begin : g_bad_aempty
        $error("sync_fifo: AEMPTY_LEVEL out of range 0..DEPTH-1");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    level;
    logic             ovf;
    logic             udf;
    logic             full;
    logic             empty;
    logic             rd_accept;
    logic             wr_accept;
    logic             flush;

    // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full      = (level == LW'(DEPTH));
    assign empty     = (level == '0);
    assign flush     = !rst_i || clr_i;
    assign rd_accept = rd_stb_i && !empty;
    assign wr_accept = wr_stb_i && (!full || rd_accept);

    always_ff @(posedge clk_i) begin
        if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= inc_ptr(wr_ptr);
            end
            if (rd_accept) begin
                rd_ptr <= inc_ptr(rd_ptr);
            end
            if (wr_accept && !rd_accept) begin
                level <= level + LW'(1);
            end else if (rd_accept && !wr_accept) begin
                level <= level - LW'(1);
            end
            if (wr_stb_i && full && !rd_accept) begin
                ovf <= 1'b1;
            end
            if (rd_stb_i && empty) begin
                udf <= 1'b1;
            end
        end
    end

    // Storage is deliberately not reset; a dropped or flushed write never lands.
    always_ff @(posedge clk_i) begin
        if (!flush && wr_accept) begin
            mem[wr_ptr] <= wr_dat_i;
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign rd_dat_o = empty ? '0 : mem[rd_ptr];
    end else begin : g_reg
        logic [WIDTH-1:0] dat;

        // A flush keeps the last read word visible; only reset zeroes it.
        always_ff @(posedge clk_i) begin
            if (!rst_i) begin
                dat <= '0;
            end else if (!clr_i && rd_accept) begin
                dat <= mem[rd_ptr];
            end
        end

        assign rd_dat_o = dat;
    end

    assign wr_full_o      = full;
    assign rd_empty_o     = empty;
    assign level_o        = level;
    assign almost_full_o  = (int'(level) >= AFULL_LEVEL);
    assign almost_empty_o = (int'(level) <= AEMPTY_LEVEL);
    assign ovf_o          = ovf;
    assign udf_o          = udf;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: two configurations share one stimulus stream and are each
// checked against a queue-based reference model plus a read-data scoreboard.
module tb_sync_fifo;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       wr_stb;
    logic [7:0] wr_dat;
    logic       rd_stb;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int D  = (g == 0) ? 5 : 16;
        localparam int AF = (g == 0) ? 3 : 14;
        localparam int AE = (g == 0) ? 1 : 2;
        localparam int FW = (g == 0) ? 0 : 1;
        localparam int LW = $clog2(D + 1);

        logic [7:0]    rd_dat;
        logic          full;
        logic          empty;
        logic [LW-1:0] level;
        logic          af;
        logic          ae;
        logic          ovf;
        logic          udf;

        sync_fifo #(
            .WIDTH(8), .DEPTH(D), .AFULL_LEVEL(AF), .AEMPTY_LEVEL(AE), .FWFT(FW)
        ) dut (
            .clk_i(clk), .rst_i(rst_n), .clr_i(clr),
            .wr_stb_i(wr_stb), .wr_dat_i(wr_dat), .wr_full_o(full),
            .rd_stb_i(rd_stb), .rd_dat_o(rd_dat), .rd_empty_o(empty),
            .level_o(level), .almost_full_o(af), .almost_empty_o(ae),
            .ovf_o(ovf), .udf_o(udf)
        );

        logic [7:0] q[$];
        logic [7:0] exp_q[$];
        logic [7:0] m_dat;
        bit         m_ovf;
        bit         m_udf;

        // Reference model: contents as a plain queue, stepped once per edge.
        initial begin
            bit rd_ok;
            bit wr_ok;
            m_dat = 8'h00;
            m_ovf = 1'b0;
            m_udf = 1'b0;
            forever begin
                @(posedge clk);
                if (!rst_n || clr) begin
                    q.delete();
                    exp_q.delete();
                    m_ovf = 1'b0;
                    m_udf = 1'b0;
                    if (!rst_n) m_dat = 8'h00;
                end else begin
                    rd_ok = rd_stb && (q.size() > 0);
                    wr_ok = wr_stb && ((q.size() < D) || rd_ok);
                    if (rd_stb && q.size() == 0) m_udf = 1'b1;
                    if (wr_stb && !wr_ok) m_ovf = 1'b1;
                    if (rd_ok) begin
                        m_dat = q.pop_front();
                        exp_q.push_back(m_dat);
                    end
                    if (wr_ok) q.push_back(wr_dat);
                end
            end
        end

        // Monitor: pops the scoreboard whenever the DUT accepted a read.
        initial begin
            bit         pend;
            logic [7:0] shown;
            logic [7:0] e;
            int         n;
            int         exp_rd;
            pend  = 1'b0;
            shown = 8'h00;
            forever begin
                @(negedge clk);
                if (pend) begin
                    chk($sformatf("i%0d_sb_pending", g), int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk($sformatf("i%0d_rd_word", g), (FW != 0) ? int'(shown) : int'(rd_dat), int'(e));
                    end
                end
                n = q.size();
                if (FW != 0) exp_rd = (n == 0) ? 0 : int'(q[0]);
                else         exp_rd = int'(m_dat);
                chk($sformatf("i%0d_level", g), int'(level), n);
                chk($sformatf("i%0d_full", g), int'(full), int'(n == D));
                chk($sformatf("i%0d_empty", g), int'(empty), int'(n == 0));
                chk($sformatf("i%0d_afull", g), int'(af), int'(n >= AF));
                chk($sformatf("i%0d_aempty", g), int'(ae), int'(n <= AE));
                chk($sformatf("i%0d_ovf", g), int'(ovf), int'(m_ovf));
                chk($sformatf("i%0d_udf", g), int'(udf), int'(m_udf));
                chk($sformatf("i%0d_rd_dat", g), int'(rd_dat), exp_rd);
                pend  = rst_n && !clr && rd_stb && !empty;
                shown = rd_dat;
            end
        end
    end

    task automatic cyc(input bit w, input logic [7:0] d, input bit r,
                       input bit c = 1'b0, input bit rb = 1'b1);
        wr_stb = w;
        wr_dat = d;
        rd_stb = r;
        clr    = c;
        rst_n  = rb;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pw;
        int pr;
        rst_n  = 1'b0;
        clr    = 1'b0;
        wr_stb = 1'b0;
        wr_dat = 8'h00;
        rd_stb = 1'b0;
        cyc(0, 8'h00, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 0);
        cyc(0, 8'h00, 0);

        // Fill past DEPTH=5, overflow, then drain past empty.
        for (int i = 0; i < 5; i++) cyc(1, 8'h11 + 8'(i), 0);
        cyc(1, 8'h99, 0);
        cyc(0, 8'h00, 0);
        for (int i = 0; i < 7; i++) cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 0, 1);

        // Wrap-around rounds.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 3; i++) cyc(1, 8'h40 + 8'(r * 3 + i), 0);
            for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1);
            cyc(0, 8'h00, 0);
        end

        // Simultaneous strobes when full, then when empty.
        cyc(0, 8'h00, 0, 1);
        for (int i = 0; i < 5; i++) cyc(1, 8'h60 + 8'(i), 0);
        cyc(1, 8'h6A, 1);
        cyc(0, 8'h00, 0);
        for (int i = 0; i < 6; i++) cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 0);
        cyc(1, 8'h77, 1);
        cyc(0, 8'h00, 0);
        cyc(0, 8'h00, 1);

        // Single write shows up on the FWFT head without a strobe.
        cyc(0, 8'h00, 0, 1);
        cyc(1, 8'hA5, 0);
        cyc(0, 8'h00, 0);
        cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 0);

        // Almost-flag thresholds while filling and draining DEPTH=16.
        cyc(0, 8'h00, 0, 1);
        for (int i = 0; i < 16; i++) cyc(1, 8'h80 + 8'(i), 0);
        cyc(0, 8'h00, 0);
        for (int i = 0; i < 17; i++) cyc(0, 8'h00, 1);

        // Flush with a write pending, then reset mid-burst.
        cyc(0, 8'h00, 0, 1);
        for (int i = 0; i < 7; i++) cyc(1, 8'hC0 + 8'(i), 0);
        cyc(1, 8'hCF, 0, 1);
        cyc(0, 8'h00, 0);
        for (int i = 0; i < 7; i++) cyc(1, 8'hD0 + 8'(i), 0);
        cyc(0, 8'h00, 1);
        cyc(1, 8'hDF, 1, 0, 0);
        cyc(1, 8'h5A, 0);
        cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 0);

        // Randomised traffic in phases with different write/read bias.
        for (int ph = 0; ph < 12; ph++) begin
            pw = (ph % 3 == 0) ? 80 : ((ph % 3 == 1) ? 30 : 55);
            pr = (ph % 3 == 0) ? 30 : ((ph % 3 == 1) ? 80 : 55);
            for (int i = 0; i < 200; i++) begin
                cyc($urandom_range(99) < pw, 8'($urandom), $urandom_range(99) < pr,
                    $urandom_range(149) == 0, $urandom_range(299) != 0);
            end
        end

        cyc(0, 8'h00, 0);
        cyc(0, 8'h00, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Single-clock, parametrised successor to the dual-clock 8-bit fifo. It keeps the same strobe/full/empty handshake and adds:
- generic width and depth, including non-power-of-two depth
- fill level and almost-full/almost-empty flags
- optional first-word-fall-through (FWFT) read mode
- synchronous flush and sticky overflow/underflow flags
It is used as a rate/burst buffer inside one clock domain, between bus front-ends and datapath blocks.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of storage words (>=2, any integer)
AFULL_LEVEL, DEPTH-2, level at or above which almost_full_o asserts (1..DEPTH)
AEMPTY_LEVEL, 1, level at or below which almost_empty_o asserts (0..DEPTH-1)
FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_i  in  1  synchronous reset, active-low (0 = reset)
clr_i  in  1  synchronous flush, active-high
wr_stb_i  in  1  write request this cycle
wr_dat_i  in  WIDTH  write data
wr_full_o  out  1  fifo holds DEPTH words
rd_stb_i  in  1  read request this cycle
rd_dat_o  out  WIDTH  read data
rd_empty_o  out  1  fifo holds 0 words
level_o  out  $clog2(DEPTH+1)  current word count
almost_full_o  out  1  level_o >= AFULL_LEVEL
almost_empty_o  out  1  level_o <= AEMPTY_LEVEL
ovf_o  out  1  sticky: write dropped while full
udf_o  out  1  sticky: read requested while empty

Behaviour:
- Reset (rst_i=0 at an edge): wr_ptr=rd_ptr=0, level_o=0, rd_empty_o=1, wr_full_o=0, almost_empty_o=1, almost_full_o=(AFULL_LEVEL==0 ? 1 : 0), ovf_o=udf_o=0, rd_dat_o=0. Storage array is not reset. Reset overrides clr_i and both strobes.
- clr_i=1 (rst_i=1): same effect as reset on pointers, level, flags, ovf_o and udf_o. rd_dat_o holds its value in FWFT=0. Strobes in the same cycle are ignored and set no error flag.
- Write accept: wr_stb_i & (!wr_full_o | rd_accept). The word is stored at mem[wr_ptr], and wr_ptr advances with wrap: DEPTH-1 -> 0. No power-of-two assumption.
- Read accept: rd_stb_i & !rd_empty_o. rd_ptr advances with the same wrap rule.
- Full and read in the same cycle: write is accepted and level is unchanged.
- Empty and write in the same cycle: read is rejected, udf_o is set, write is accepted.
- Level update: level_o += wr_accept - rd_accept.
- Flag timing: full, empty, almost_full_o and almost_empty_o are decoded from the level register. They change in the cycle after the accepting edge (one-cycle latency).
- FWFT=0: on a read-accept edge, rd_dat_o <= mem[rd_ptr]. Data is valid from the cycle after the strobe and holds until the next accepted read.
- FWFT=1: rd_dat_o = mem[rd_ptr] whenever rd_empty_o=0 and is forced to 0 when empty. Head data is visible in the cycle after the first write lands. rd_stb_i consumes the displayed word.
- ovf_o: set at an edge with wr_stb_i & wr_full_o & !rd_accept. The dropped word does not modify memory. Cleared only by reset or clr_i.
- udf_o: set at an edge with rd_stb_i & rd_empty_o. Pointers, level and rd_dat_o are unchanged. Cleared only by reset or clr_i.
- Reset asserted mid-burst: contents are discarded; the first write after release lands at mem[0].
- No combinational path from wr_stb_i/rd_stb_i to any output.
- In FWFT=1, rd_dat_o depends combinationally only on registered state and memory.

Test Plan:
1. WIDTH=8, DEPTH=5, FWFT=0, after reset: write 0x11..0x15 -> wr_full_o=1, level_o=5. Write 0x99 -> ovf_o=1, memory unchanged. Five reads -> 0x11..0x15 in order, each one cycle after its strobe; then rd_empty_o=1.
2. DEPTH=5, wrap-around: 3 writes, 3 reads, repeated 4 times (pointers wrap past 4 -> 0) -> data sequence intact, level_o returns to 0 every round.
3. Simultaneous strobes: when full with level 5, wr+rd together -> level_o stays 5, oldest word out, new word stored. When empty, wr+rd together -> udf_o=1, level_o becomes 1, rd_dat_o unchanged.
4. FWFT=1, DEPTH=16: single write of 0xA5 -> rd_dat_o=0xA5 the next cycle with no strobe. rd_stb_i -> rd_empty_o=1, rd_dat_o=0.
5. AFULL_LEVEL=14, AEMPTY_LEVEL=2, DEPTH=16: fill word by word -> almost_empty_o deasserts at level 3, almost_full_o asserts at level 14. Both flags toggle back at the same levels while draining.
6. Flush and reset: fill 7 words, set ovf_o, then pulse clr_i together with wr_stb_i -> level_o=0, ovf_o=0, write ignored. Repeat with rst_i=0 for one cycle -> all outputs at reset values; next write lands and reads back correctly.
